// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: holds/releases the ball, keeps both scores, picks the
// serve direction and detects end of match. All outputs are registered.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES  = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_run,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [3:0] player1_score,
  output logic [3:0] player2_score,
  output logic       game_over,
  output logic       winner
);

  localparam int unsigned SCORE_W    = 4;
  localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > HOLD_FRAMES) ? SERVE_FRAMES : HOLD_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    SCORED = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   frame_inc;
  logic               start_q;
  logic               start_rise;
  logic               serve_done;
  logic               hold_done;
  logic               miss_both;
  logic               miss_any;
  logic               win_reached;

  logic               ball_run_q, ball_run_d;
  logic               ball_center_q, ball_center_d;
  logic               serve_dir_q, serve_dir_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;

  assign start_rise  = start & ~start_q;
  assign frame_inc   = frame_cnt_q + CNT_W'(1);
  assign serve_done  = refresh_tick && (frame_inc == CNT_W'(SERVE_FRAMES));
  assign hold_done   = refresh_tick && (frame_inc == CNT_W'(HOLD_FRAMES));
  assign miss_both   = miss_left & miss_right;
  assign miss_any    = miss_left | miss_right;
  assign win_reached = (p1_score_q == WIN_VAL) || (p2_score_q == WIN_VAL);

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      start_q       <= 1'b0;
      ball_run_q    <= 1'b0;
      ball_center_q <= 1'b1;
      serve_dir_q   <= 1'b1;
      p1_score_q    <= '0;
      p2_score_q    <= '0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      start_q       <= start;
      ball_run_q    <= ball_run_d;
      ball_center_q <= ball_center_d;
      serve_dir_q   <= serve_dir_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_rise) state_d = SERVE;
      SERVE:   if (serve_done) state_d = PLAY;
      PLAY: begin
        if (miss_both)     state_d = SERVE;
        else if (miss_any) state_d = SCORED;
      end
      SCORED:  if (hold_done) state_d = win_reached ? OVER : SERVE;
      OVER:    if (start_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; every state change restarts the frame count
  always_comb begin
    frame_cnt_d   = refresh_tick ? frame_inc : frame_cnt_q;
    ball_run_d    = (state_d == PLAY);
    ball_center_d = (state_d != PLAY);
    game_over_d   = (state_d == OVER);
    serve_dir_d   = serve_dir_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    winner_d      = winner_q;

    if (state_d != state_q) frame_cnt_d = '0;

    unique case (state_q)
      PLAY: begin
        if (miss_right && !miss_left) begin
          if (p1_score_q != SCORE_MAX) p1_score_d = p1_score_q + SCORE_W'(1);
          serve_dir_d = 1'b1;
        end else if (miss_left && !miss_right) begin
          if (p2_score_q != SCORE_MAX) p2_score_d = p2_score_q + SCORE_W'(1);
          serve_dir_d = 1'b0;
        end
      end
      SCORED: begin
        // The player who just scored is the one the next serve heads toward
        if (hold_done && win_reached) winner_d = ~serve_dir_q;
      end
      OVER: begin
        if (start_rise) begin
          p1_score_d  = '0;
          p2_score_d  = '0;
          serve_dir_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ball_run      = ball_run_q;
  assign ball_center   = ball_center_q;
  assign serve_dir     = serve_dir_q;
  assign player1_score = p1_score_q;
  assign player2_score = p2_score_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with WIN_SCORE = 3 and default frame counts.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_tick = 1'b0;
  logic       start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_run;
  logic       ball_center;
  logic       serve_dir;
  logic [3:0] player1_score;
  logic [3:0] player2_score;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;

  pong_match_ctrl #(
    .WIN_SCORE   (3),
    .SERVE_FRAMES(60),
    .HOLD_FRAMES (90)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .start        (start),
    .miss_left    (miss_left),
    .miss_right   (miss_right),
    .ball_run     (ball_run),
    .ball_center  (ball_center),
    .serve_dir    (serve_dir),
    .player1_score(player1_score),
    .player2_score(player2_score),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      refresh_tick = 1'b1;
      step();
      refresh_tick = 1'b0;
      step();
    end
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic pulse_miss(input logic l, input logic r);
    miss_left  = l;
    miss_right = r;
    step();
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ball_run"},    4'(ball_run),    4'd0);
    chk({tag, ".ball_center"}, 4'(ball_center), 4'd1);
    chk({tag, ".serve_dir"},   4'(serve_dir),   4'd1);
    chk({tag, ".p1"},          player1_score,   4'd0);
    chk({tag, ".p2"},          player2_score,   4'd0);
    chk({tag, ".game_over"},   4'(game_over),   4'd0);
    chk({tag, ".winner"},      4'(winner),      4'd0);
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk_reset_vals("rst");

    // 1: serve period then release
    press_start();
    chk("t1.center_serve", 4'(ball_center), 4'd1);
    ticks(59);
    chk("t1.run_59", 4'(ball_run), 4'd0);
    ticks(1);
    chk("t1.run_60", 4'(ball_run), 4'd1);
    chk("t1.center_play", 4'(ball_center), 4'd0);

    // 2: player 1 scores
    pulse_miss(1'b0, 1'b1);
    chk("t2.p1", player1_score, 4'd1);
    chk("t2.dir", 4'(serve_dir), 4'd1);
    chk("t2.run", 4'(ball_run), 4'd0);
    chk("t2.center", 4'(ball_center), 4'd1);
    ticks(90);
    ticks(59);
    chk("t2.serve_59", 4'(ball_run), 4'd0);
    ticks(1);
    chk("t2.serve_60", 4'(ball_run), 4'd1);

    // 3: fresh match, player 2 wins 3-0
    reset = 1'b1;
    step();
    reset = 1'b0;
    press_start();
    ticks(60);
    for (int k = 1; k <= 3; k++) begin
      pulse_miss(1'b1, 1'b0);
      chk("t3.p2", player2_score, 4'(k));
      chk("t3.dir", 4'(serve_dir), 4'd0);
      ticks(90);
      if (k < 3) ticks(60);
    end
    chk("t3.game_over", 4'(game_over), 4'd1);
    chk("t3.winner", 4'(winner), 4'd1);
    chk("t3.p1", player1_score, 4'd0);
    chk("t3.p2_final", player2_score, 4'd3);
    chk("t3.run", 4'(ball_run), 4'd0);
    pulse_miss(1'b1, 1'b0);
    step();
    pulse_miss(1'b0, 1'b1);
    step();
    chk("t3.p1_frozen", player1_score, 4'd0);
    chk("t3.p2_frozen", player2_score, 4'd3);
    chk("t3.over_hold", 4'(game_over), 4'd1);

    // 4: restart from OVER, start held does not skip IDLE
    start = 1'b1;
    step();
    chk("t4.p1", player1_score, 4'd0);
    chk("t4.p2", player2_score, 4'd0);
    chk("t4.game_over", 4'(game_over), 4'd0);
    chk("t4.dir", 4'(serve_dir), 4'd1);
    ticks(70);
    chk("t4.held_idle", 4'(ball_run), 4'd0);
    start = 1'b0;
    step();
    press_start();
    ticks(60);
    chk("t4.run_after_press", 4'(ball_run), 4'd1);

    // 5: simultaneous misses, with serve_dir = 0 beforehand
    pulse_miss(1'b1, 1'b0);
    ticks(90);
    ticks(60);
    chk("t5.pre_dir", 4'(serve_dir), 4'd0);
    pulse_miss(1'b1, 1'b1);
    chk("t5.p1", player1_score, 4'd0);
    chk("t5.p2", player2_score, 4'd1);
    chk("t5.dir", 4'(serve_dir), 4'd0);
    chk("t5.run", 4'(ball_run), 4'd0);
    ticks(59);
    chk("t5.serve_59", 4'(ball_run), 4'd0);
    ticks(1);
    chk("t5.serve_60", 4'(ball_run), 4'd1);

    // 6: reset in SCORED with scores 2/1
    pulse_miss(1'b0, 1'b1);
    ticks(90);
    ticks(60);
    pulse_miss(1'b0, 1'b1);
    ticks(10);
    chk("t6.p1_pre", player1_score, 4'd2);
    chk("t6.p2_pre", player2_score, 4'd1);
    reset = 1'b1;
    step();
    chk_reset_vals("t6");
    reset = 1'b0;
    ticks(70);
    chk("t6.idle_after", 4'(ball_run), 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
